fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the decoder.
//  - Holds the PC and issues one 32-bit read at a time to instruction memory.
//  - Buffers the returned word in a single-entry output register; inst feeds the decoder's inst input.
//  - Accepts branch/jump redirects and discards any in-flight stale fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0013  value driven on inst while inst_valid=0 (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req        out  1   read request valid
//  imem_addr       out  32  read address, word aligned
//  imem_ready      in   1   memory accepts request this cycle (imem_req & imem_ready)
//  imem_rvalid     in   1   read data valid; in order, at most one outstanding
//  imem_rdata      in   32  read data
//  redirect_valid  in   1   load new PC (taken branch/JAL/JALR)
//  redirect_pc     in   32  redirect target
//  inst_valid      out  1   inst/inst_pc hold a fetched instruction
//  inst_ready      in   1   downstream consumes inst this cycle (inst_valid & inst_ready)
//  inst            out  32  fetched instruction word to decoder
//  inst_pc         out  32  address of inst
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC.
//  Reset asserted mid-operation clears all state immediately.
//  States:
//  - IDLE:  one cycle after reset release -> REQ.
//  - REQ:   imem_req=1 only when (!inst_valid | inst_ready); imem_addr=pc.
//           On imem_req & imem_ready -> WAIT.
//           imem_addr is held stable while imem_req=1 and not accepted; a redirect is the only exception.
//  - WAIT:  imem_req=0. On imem_rvalid: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, -> REQ.
//  - DRAIN: imem_req=0. Stale fetch outstanding; on imem_rvalid drop data -> REQ.
//  imem_rvalid is ignored in IDLE and REQ. Memory never asserts rvalid in the same cycle as acceptance.
//  Latency: request accepted at cycle N, rvalid at N+k (k>=1) -> inst_valid from N+k+1.
//  Peak rate: one instruction per 2 cycles.
//  Output buffer:
//  - inst/inst_pc/inst_valid are stable while inst_valid & !inst_ready.
//  - inst_valid clears on consume unless refilled the same cycle.
//  - inst=NOP_INST whenever inst_valid=0.
//  - inst_ready is ignored while inst_valid=0.
//  Redirect (priority over everything except reset):
//  - pc <= {redirect_pc[31:2],2'b00}; inst_valid<=0 (buffer flushed).
//  - In REQ, not accepted: stay REQ; imem_addr shows the new pc next cycle.
//  - In REQ, accepted the same cycle: -> DRAIN.
//  - In WAIT without rvalid: -> DRAIN.
//  - In WAIT with rvalid the same cycle: data dropped, -> REQ.
//  - In DRAIN: pc updated, stay DRAIN; rvalid the same cycle -> REQ.
//  - In IDLE: pc updated, -> REQ.
//  Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). pc[1:0] is always 0.
// TESTING
//  1. RESET_PC=0x100; release rst_n; imem_ready=1; rvalid=1 one cycle later with 0x00500093
//     -> imem_addr=0x100, then inst_valid=1, inst=0x00500093, inst_pc=0x100; next imem_addr=0x104.
//  2. inst_ready=0 for 5 cycles with inst_valid=1 -> imem_req=0, inst/inst_pc unchanged;
//     inst_ready=1 -> imem_req=1 that cycle, addr=inst_pc+4.
//  3. redirect 0x200 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF
//     -> inst_valid stays 0, data dropped, next imem_addr=0x200.
//  4. redirect 0x300 in REQ with imem_ready=0 -> imem_addr=0x300 next cycle;
//     redirect coinciding with rvalid -> data dropped, next addr=target.
//  5. pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000;
//     redirect_pc=0x203 -> imem_addr=0x200, later inst_pc=0x200.
//  6. Assert rst_n low during WAIT -> outputs take reset values immediately;
//     a late rvalid after release is ignored; first req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding word read at a time,
// and buffers the returned instruction in a single-entry register feeding the decoder.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | presenting pc to memory, waiting for acceptance
// WAIT  | request accepted, waiting for read data
// DRAIN | stale request outstanding after a redirect; its data is dropped
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;

  // Only fetch when the output slot is free or being drained this cycle.
  assign imem_req   = (state_q == REQ) && (!valid_q || inst_ready);
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = valid_q ? inst_q : NOP_INST;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;

    if (valid_q && inst_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req && imem_ready) state_d = redirect_valid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          if (!redirect_valid) begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides any sequential update and flushes the buffer.
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h0000_0003;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// traffic against a memory model and an in-order expected-PC reference.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req"},     {31'd0, imem_req},   32'd0);
    check({tag, " addr"},    imem_addr,           RPC);
    check({tag, " valid"},   {31'd0, inst_valid}, 32'd0);
    check({tag, " inst"},    inst,                NOP);
    check({tag, " inst_pc"}, inst_pc,             RPC);
  endtask

  // random-phase model state
  logic        outstanding;
  int          delay;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  int          consumed;
  logic        p_valid, p_iready, p_redir, p_req, p_mready;
  logic [31:0] p_inst, p_inst_pc, p_addr;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(negedge clk);
    #1 check_reset_vals("reset");

    // 1: first fetch
    rst_n = 1'b1;
    next_cyc();
    imem_ready = 1'b1;
    #1;
    check("t1 req", {31'd0, imem_req}, 32'd1);
    check("t1 addr", imem_addr, 32'h100);
    next_cyc();
    imem_ready = 1'b0;
    check("t1 wait req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    next_cyc();
    imem_rvalid = 1'b0;
    #1;
    check("t1 valid", {31'd0, inst_valid}, 32'd1);
    check("t1 inst", inst, 32'h0050_0093);
    check("t1 inst_pc", inst_pc, 32'h100);
    check("t1 next addr", imem_addr, 32'h104);

    // 2: backpressure holds the buffer and suppresses fetch
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2 req held", {31'd0, imem_req}, 32'd0);
      check("t2 inst held", inst, 32'h0050_0093);
      check("t2 pc held", inst_pc, 32'h100);
      next_cyc();
    end
    inst_ready = 1'b1;
    #1;
    check("t2 req on ready", {31'd0, imem_req}, 32'd1);
    check("t2 addr", imem_addr, 32'h104);
    next_cyc();
    inst_ready = 1'b0; imem_ready = 1'b0;
    #1;
    check("t2 consumed", {31'd0, inst_valid}, 32'd0);
    check("t2 nop", inst, NOP);

    // 3: redirect in WAIT, stale data later dropped
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    next_cyc();
    redirect_valid = 1'b0;
    next_cyc();
    next_cyc();
    #1 check("t3 drain req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cyc();
    imem_rvalid = 1'b0;
    #1;
    check("t3 dropped", {31'd0, inst_valid}, 32'd0);
    check("t3 req", {31'd0, imem_req}, 32'd1);
    check("t3 addr", imem_addr, 32'h200);

    // 4: redirect in REQ without acceptance, then redirect with rvalid
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    next_cyc();
    redirect_valid = 1'b0;
    #1 check("t4 addr", imem_addr, 32'h300);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1357_9BDF;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    next_cyc();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    #1;
    check("t4 dropped", {31'd0, inst_valid}, 32'd0);
    check("t4 addr", imem_addr, 32'h400);

    // 5: pc wrap and misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cyc();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    #1 check("t5 addr top", imem_addr, 32'hFFFF_FFFC);
    next_cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    next_cyc();
    imem_rvalid = 1'b0;
    #1;
    check("t5 top pc", inst_pc, 32'hFFFF_FFFC);
    check("t5 wrap addr", imem_addr, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    check("t5 align addr", imem_addr, 32'h200);
    check("t5 flushed", {31'd0, inst_valid}, 32'd0);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    next_cyc();
    imem_rvalid = 1'b0;
    #1;
    check("t5 inst_pc", inst_pc, 32'h200);
    check("t5 inst", inst, 32'h2222_2222);

    // 6: reset during WAIT, late rvalid ignored
    inst_ready = 1'b1; imem_ready = 1'b1;
    next_cyc();
    inst_ready = 1'b0; imem_ready = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals("t6 async");
    next_cyc();
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    next_cyc();
    #1;
    check("t6 req", {31'd0, imem_req}, 32'd1);
    check("t6 addr", imem_addr, RPC);
    next_cyc();
    imem_rvalid = 1'b0;
    #1;
    check("t6 ignored", {31'd0, inst_valid}, 32'd0);
    check("t6 addr held", imem_addr, RPC);

    // Randomized traffic
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    outstanding = 1'b0; delay = 0; pend_addr = '0; exp_pc = RPC; consumed = 0;
    p_valid = 1'b0; p_iready = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_mready = 1'b0;
    p_inst = '0; p_inst_pc = '0; p_addr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outstanding) begin
        delay--;
        if (delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          outstanding = 1'b0;
        end
      end
      imem_ready     = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      #1;
      if (!inst_valid) check("r nop", inst, NOP);
      if (p_valid && !p_iready && !p_redir) begin
        check("r hold valid", {31'd0, inst_valid}, 32'd1);
        check("r hold inst", inst, p_inst);
        check("r hold pc", inst_pc, p_inst_pc);
      end
      if (p_req && !p_mready && !p_redir && imem_req)
        check("r addr stable", imem_addr, p_addr);
      if (inst_valid && inst_ready) begin
        check("r inst_pc", inst_pc, exp_pc);
        check("r inst", inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      if (imem_req && imem_ready) begin
        check("r one outstanding", {31'd0, outstanding}, 32'd0);
        check("r addr align", {30'd0, imem_addr[1:0]}, 32'd0);
        outstanding = 1'b1;
        pend_addr   = imem_addr;
        delay       = $urandom_range(1, 3);
      end
      p_valid = inst_valid; p_iready = inst_ready; p_redir = redirect_valid;
      p_req = imem_req; p_mready = imem_ready;
      p_inst = inst; p_inst_pc = inst_pc; p_addr = imem_addr;
      next_cyc();
    end
    check("r progress", {31'd0, consumed > 200}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
